// File: rtl/nv_ram_rwsp_4x64_fifo_ctrl.sv
// rtl/nv_ram_rwsp_4x64_fifo_ctrl.sv - valid/ready FIFO sequencer for a 4x64 two-port RAM with a 2-stage read pipeline
//
// Purpose: owns the write/read pointers and occupancy of an external two-port
// RAM whose read address is registered (ram_re) and whose output register is
// separately enabled (ram_ore). The two read stages are presented to the
// consumer as a plain valid/ready interface.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   wr_pvld/wr_prdy/wr_pd     producer handshake and data
//   rd_pvld/rd_prdy/rd_pd     consumer handshake and data (rd_pd = ram_dout)
//   ram_wa/ram_we/ram_di      RAM write port
//   ram_ra/ram_re             RAM read-address register capture
//   ram_ore/ram_dout          RAM output-register enable and registered data
//   fifo_count/fifo_idle      entries held (RAM + output register), empty flag
module nv_ram_rwsp_4x64_fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   fifo_count,
    output logic          fifo_idle
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    // occ: written, not yet captured by the output register.
    // unissued: written, not yet presented to the read-address register.
    logic [AW:0]   occ_q, occ_d;
    logic [AW:0]   unissued_q, unissued_d;
    logic          s1_vld_q, s1_vld_d;
    logic          s2_vld_q, s2_vld_d;

    // A RAM location is released only when its data is captured by ore, so
    // wr_ptr can never reach an address still sitting in the read pipeline.
    always_comb begin
        wr_prdy = !rst && (occ_q < FULL);
        ram_we  = wr_pvld && wr_prdy;
        ram_ore = !rst && s1_vld_q && (!s2_vld_q || rd_prdy);
        // Stage 1 may reload in the same cycle its current address moves on.
        ram_re  = !rst && (unissued_q != '0) && (!s1_vld_q || ram_ore);
    end

    assign ram_wa     = wr_ptr_q;
    assign ram_di     = wr_pd;
    assign ram_ra     = rd_ptr_q;
    assign rd_pvld    = s2_vld_q;
    assign rd_pd      = ram_dout;
    assign fifo_count = occ_q + {{AW{1'b0}}, s2_vld_q};
    assign fifo_idle  = (fifo_count == '0);

    always_comb begin
        wr_ptr_d   = ram_we ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = ram_re ? rd_ptr_q + AW'(1) : rd_ptr_q;
        occ_d      = occ_q + {{AW{1'b0}}, ram_we} - {{AW{1'b0}}, ram_ore};
        unissued_d = unissued_q + {{AW{1'b0}}, ram_we} - {{AW{1'b0}}, ram_re};
        s1_vld_d   = s1_vld_q;
        if (ram_re) begin
            s1_vld_d = 1'b1;
        end else if (ram_ore) begin
            s1_vld_d = 1'b0;
        end
        s2_vld_d = s2_vld_q;
        if (ram_ore) begin
            s2_vld_d = 1'b1;
        end else if (s2_vld_q && rd_prdy) begin
            s2_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            unissued_q <= '0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            unissued_q <= unissued_d;
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
        end
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ_q <= FULL);
    a_unissued_le_occ: assert property (@(posedge clk) disable iff (rst) unissued_q <= occ_q);

endmodule

// File: tb/tb_nv_ram_rwsp_4x64_fifo_ctrl.sv
// tb/tb_nv_ram_rwsp_4x64_fifo_ctrl.sv - self-checking bench for nv_ram_rwsp_4x64_fifo_ctrl with a behavioural RAM
module tb_nv_ram_rwsp_4x64_fifo_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_pvld = 1'b0;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd = '0;
    logic          rd_pvld;
    logic          rd_prdy = 1'b0;
    logic [DW-1:0] rd_pd;
    logic [AW-1:0] ram_wa;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic          ram_ore;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   fifo_count;
    logic          fifo_idle;

    always #5 clk = ~clk;

    nv_ram_rwsp_4x64_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
        .ram_dout(ram_dout),
        .fifo_count(fifo_count), .fifo_idle(fifo_idle)
    );

    // Two-port RAM: registered read address, separately enabled output register.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_reg;
    logic [DW-1:0] dout_reg;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_reg <= ram_ra;
        if (ram_ore) dout_reg <= mem[ra_reg];
    end
    assign ram_dout = dout_reg;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] sb[$];
    int push_cnt;
    int pop_cnt;
    bit inflight;
    logic [AW-1:0] inflight_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample mid-cycle,
    // then score the handshakes that will complete on the next edge.
    task automatic cyc(input logic wv, input logic [DW-1:0] d, input logic rr);
        bit hazard;
        @(posedge clk);
        #1;
        wr_pvld = wv;
        wr_pd   = d;
        rd_prdy = rr;
        #4;
        chk("count", 64'(fifo_count), 64'(sb.size()));
        chk("idle", 64'(fifo_idle), 64'(sb.size() == 0));
        hazard = (ram_we && inflight && ram_wa == inflight_addr) ||
                 (ram_we && ram_re && ram_wa == ram_ra);
        chk("no_overwrite", 64'(hazard), 64'd0);
        if (ram_we && !wr_prdy) chk("we_without_prdy", 64'd1, 64'd0);
        if (rd_pvld && rd_prdy) begin
            pop_cnt++;
            if (sb.size() == 0) chk("pop_on_empty", 64'd1, 64'd0);
            else chk("data", rd_pd, sb.pop_front());
        end
        if (wr_pvld && wr_prdy) begin
            sb.push_back(wr_pd);
            push_cnt++;
        end
        if (ram_re) begin
            inflight = 1'b1;
            inflight_addr = ram_ra;
        end else if (ram_ore) begin
            inflight = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr_pvld = 1'b1;
        wr_pd = 64'hBAD;
        rd_prdy = 1'b1;
        #4;
        chk("rst_wr_prdy", 64'(wr_prdy), 64'd0);
        chk("rst_we", 64'(ram_we), 64'd0);
        chk("rst_re", 64'(ram_re), 64'd0);
        chk("rst_ore", 64'(ram_ore), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        sb.delete();
        inflight = 1'b0;
        #4;
        chk("post_rst_pvld", 64'(rd_pvld), 64'd0);
        chk("post_rst_count", 64'(fifo_count), 64'd0);
        chk("post_rst_idle", 64'(fifo_idle), 64'd1);
        chk("post_rst_wa", 64'(ram_wa), 64'd0);
        chk("post_rst_ra", 64'(ram_ra), 64'd0);
        chk("post_rst_wr_prdy", 64'(wr_prdy), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || !fifo_idle) && n < budget) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 64'd1);
    endtask

    typedef struct {
        logic          wv;
        logic          rr;
        logic [DW-1:0] d;
        logic [5:0]    fl;   // {wr_prdy, ram_we, ram_re, ram_ore, rd_pvld, fifo_idle}
        logic [AW:0]   cnt;
        logic          chk_pd;
        logic [DW-1:0] pd;
    } vec_t;

    localparam logic [DW-1:0] WD = 64'hDEADBEEF_00000001;
    localparam logic [DW-1:0] WA = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] WB = 64'hFEDC_BA98_7654_3210;

    initial begin
        vec_t vt[12];
        int lat;
        int n;

        vt[0]  = '{1'b1, 1'b1, WD, 6'b110001, 3'd0, 1'b0, 64'd0};
        vt[1]  = '{1'b0, 1'b1, '0, 6'b101000, 3'd1, 1'b0, 64'd0};
        vt[2]  = '{1'b0, 1'b1, '0, 6'b100100, 3'd1, 1'b0, 64'd0};
        vt[3]  = '{1'b0, 1'b1, '0, 6'b100010, 3'd1, 1'b1, WD};
        vt[4]  = '{1'b0, 1'b1, '0, 6'b100001, 3'd0, 1'b0, 64'd0};
        vt[5]  = '{1'b1, 1'b0, WA, 6'b110001, 3'd0, 1'b0, 64'd0};
        vt[6]  = '{1'b1, 1'b0, WB, 6'b111000, 3'd1, 1'b0, 64'd0};
        vt[7]  = '{1'b0, 1'b0, '0, 6'b101100, 3'd2, 1'b0, 64'd0};
        vt[8]  = '{1'b0, 1'b0, '0, 6'b100010, 3'd2, 1'b1, WA};
        vt[9]  = '{1'b0, 1'b1, '0, 6'b100110, 3'd2, 1'b1, WA};
        vt[10] = '{1'b0, 1'b1, '0, 6'b100010, 3'd1, 1'b1, WB};
        vt[11] = '{1'b0, 1'b1, '0, 6'b100001, 3'd0, 1'b0, 64'd0};

        push_cnt = 0;
        pop_cnt = 0;
        inflight = 1'b0;
        #2;
        chk("in_rst_wr_prdy", 64'(wr_prdy), 64'd0);
        do_reset();

        // Single word latency and a short stalled pair.
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].wv, vt[i].d, vt[i].rr);
            chk($sformatf("vec%0d_flags", i),
                64'({wr_prdy, ram_we, ram_re, ram_ore, rd_pvld, fifo_idle}), 64'(vt[i].fl));
            chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vt[i].cnt));
            if (vt[i].chk_pd) chk($sformatf("vec%0d_pd", i), rd_pd, vt[i].pd);
        end

        // Fill with the consumer stalled, then push/pop at full.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 64'(k), 1'b0);
            chk($sformatf("fill_accept%0d", k), 64'(ram_we), 64'd1);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 64'd5, 1'b0);
            chk("full_wr_prdy", 64'(wr_prdy), 64'd0);
            chk("full_count", 64'(fifo_count), 64'd5);
        end
        pop_cnt = 0;
        cyc(1'b1, 64'd5, 1'b1);
        chk("full_pop_wr_prdy", 64'(wr_prdy), 64'd0);
        chk("full_pop_ore", 64'(ram_ore), 64'd1);
        cyc(1'b1, 64'd5, 1'b1);
        chk("after_pop_accept", 64'(ram_we), 64'd1);
        drain(30);
        chk("fill_pop_total", 64'(pop_cnt), 64'd6);

        // Streaming at one word per cycle.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 64'(100 + i), 1'b1);
            chk("stream_wr_prdy", 64'(wr_prdy), 64'd1);
            if (i >= 3) chk("stream_rd_pvld", 64'(rd_pvld), 64'd1);
        end
        drain(20);

        // Reset with data queued and valid at the output.
        for (int k = 0; k < 3; k++) cyc(1'b1, 64'(200 + k), 1'b0);
        n = 0;
        while (!rd_pvld && n < 10) begin
            cyc(1'b0, '0, 1'b0);
            n++;
        end
        chk("pre_rst_pvld", 64'(rd_pvld), 64'd1);
        do_reset();
        cyc(1'b1, 64'h55, 1'b1);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b0, '0, 1'b1);
            if (rd_pvld) begin
                lat = k;
                break;
            end
        end
        chk("post_rst_latency", 64'(lat), 64'd3);
        drain(10);

        // Random traffic with random back-pressure.
        do_reset();
        push_cnt = 0;
        n = 0;
        while (push_cnt < 1000 && n < 20000) begin
            cyc((push_cnt < 1000) && ($urandom_range(0, 3) != 0),
                {$urandom, $urandom}, $urandom_range(0, 1) == 1);
            n++;
        end
        chk("random_pushed", 64'(push_cnt), 64'd1000);
        drain(40);
        chk("random_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nv_ram_rwsp_4x64_fifo_ctrl.md
Name: nv_ram_rwsp_4x64_fifo_ctrl

Overview:
- Flow-control sequencer that turns the 4x64 two-port RAM (registered read address, separately enabled output register) into a 4-deep valid/ready FIFO.
- Owns the write/read pointers and occupancy, and drives the RAM's wa/we/di, ra/re and ore pins.
- Hides the RAM's 2-stage read pipeline behind a ready/valid output, with back-pressure that never corrupts in-flight data.
- Sits between a producer and consumer inside a datapath; the RAM is instantiated alongside it, not inside.

Parameters:
- DEPTH, 4, number of RAM entries; must be a power of 2.
- AW, 2, RAM address width; equals log2(DEPTH).
- DW, 64, data width.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  reset: synchronous, active-high.
- wr_pvld  input  1  producer data valid.
- wr_prdy  output  1  controller can accept a write.
- wr_pd  input  DW  producer data.
- rd_pvld  output  1  output data valid.
- rd_prdy  input  1  consumer ready.
- rd_pd  output  DW  output data; wired from ram_dout.
- ram_wa  output  AW  RAM write address.
- ram_we  output  1  RAM write enable.
- ram_di  output  DW  RAM write data; equals wr_pd.
- ram_ra  output  AW  RAM read address.
- ram_re  output  1  RAM read-address capture enable.
- ram_ore  output  1  RAM output-register enable.
- ram_dout  input  DW  RAM registered output.
- fifo_count  output  AW+1  entries held: in RAM plus in the output register (0..DEPTH+1).
- fifo_idle  output  1  no entries held anywhere.

Behaviour:
- State:
  - wr_ptr, rd_ptr (AW bits, wrap DEPTH-1 -> 0).
  - occ (AW+1): entries written and not yet captured by ore.
  - unissued (AW+1): entries written and not yet issued by re.
  - s1_vld: RAM address register holds a live address.
  - s2_vld: RAM output register holds live data.
- Reset: while rst=1 and after its edge, all state is 0. While rst=1, wr_prdy, ram_we, ram_re and ram_ore are forced to 0.
- Reset outputs after the edge: rd_pvld=0, fifo_count=0, fifo_idle=1, ram_wa=0, ram_ra=0.
- Reset mid-operation discards all contents, including pending output data. A wr_pvld in the reset cycle is not accepted.
- Write side:
  - wr_prdy = (occ < DEPTH).
  - ram_we = wr_pvld & wr_prdy; ram_wa = wr_ptr.
  - On ram_we, wr_ptr increments and occ and unissued each +1.
  - Write is not gated by rd_prdy.
- Read stage 1:
  - ram_re = (unissued != 0) & (!s1_vld | ram_ore); ram_ra = rd_ptr.
  - On ram_re, rd_ptr increments, unissued -1, and s1_vld is set.
  - Otherwise, s1_vld is cleared when ram_ore fires.
- Read stage 2:
  - ram_ore = s1_vld & (!s2_vld | rd_prdy).
  - On ram_ore, s2_vld=1 and occ -1: the location is free only once the data is captured, so a write can never overwrite M[ra_d] while it is still pending.
  - Otherwise, s2_vld is cleared when rd_pvld & rd_prdy.
- rd_pvld = s2_vld; rd_pd = ram_dout.
- Simultaneous events: increments and decrements in the same cycle net out (occ and unissued unchanged).
- Pointer wrap is pure modulo DEPTH.
- Latency:
  - A write accepted at edge N makes unissued != 0 in cycle N+1; ram_re fires in N+1, ram_ore in N+2, and rd_pvld=1 in cycle N+3.
  - A write and a re to the same address never coincide, because unissued is registered.
- Throughput: 1 word/cycle sustained with rd_prdy=1. rd_prdy low freezes stage 2, then stage 1, then the RAM fills to wr_prdy=0.
- Counts and flags:
  - fifo_count = occ + s2_vld; maximum DEPTH+1.
  - fifo_idle = (fifo_count==0).
- Illegal counts: occ>DEPTH and unissued>occ are illegal and are covered by assertions.
- Data order: strict FIFO; no reordering, no drop.

Test Plan:
- Single word: write 0xDEADBEEF_00000001 at edge 0 with rd_prdy=1 -> ram_re in cycle 1, ram_ore in cycle 2, rd_pvld=1 with rd_pd=0xDEADBEEF_00000001 in cycle 3; fifo_idle=1 at cycle 4.
- Fill with stall: rd_prdy=0, write 0..5 back-to-back -> accepted words 0..4 (fifo_count=5), wr_prdy=0 after word 4 is captured. Raise rd_prdy -> output is 0,1,2,3,4 in order with no duplicates, then word 5 once it is re-offered.
- Streaming: wr_pvld=rd_prdy=1 for 32 cycles, incrementing data -> after 3-cycle fill, one word/cycle out in order; wr_prdy never drops; pointers wrap 8 times.
- Random back-pressure: 1000 words with rd_prdy random 50% -> scoreboard matches exactly; no ram_we to any address between that address's ram_re and its ram_ore.
- Reset mid-flight: 3 words queued with rd_pvld=1, assert rst for 1 cycle -> next cycle rd_pvld=0, fifo_count=0, wr_prdy=1. A new write 0x55 is the next word out at the 3-cycle latency.
- Simultaneous push/pop at full: occ=4, s2_vld=1, rd_prdy=1 and wr_pvld=1 -> ore captures and the write is refused that cycle (wr_prdy based on registered occ), accepted the next cycle; fifo_count stays consistent with the scoreboard.
